// File: rtl/gsim_pkg.sv
// Shared defaults and helpers for the GSIM update processing element pipeline.
package gsim_pkg;

    localparam int IN_W_DEF  = 34;
    localparam int B_W_DEF   = 16;
    localparam int TAG_W_DEF = 10;

    localparam int C1_DEF = 1;
    localparam int C2_DEF = -6;
    localparam int C3_DEF = 13;

    // 3277 / 2^16 approximates 1/20
    localparam int DIV_MUL   = 3277;
    localparam int DIV_SHIFT = 16;

    function automatic int gsim_lat(input bit div_en);
        return div_en ? 3 : 2;
    endfunction

endpackage

// File: rtl/gsim_pe_slot.sv
// One-entry valid/ready pipeline register; holds its payload until the next stage takes it.
module gsim_pe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/gsim_pe_pipe.sv
// GSIM update PE: acc = b + C1(in_1+in_2) + C2(in_3+in_4) + C3(in_5+in_6), valid/ready pipelined.
// Define GSIM_PE_DIV_EN to add a third stage applying (acc*3277)>>>16 (about acc/20).
module gsim_pe_pipe
    import gsim_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int B_W   = B_W_DEF,
    parameter int OUT_W = IN_W + 4,
    parameter int TAG_W = TAG_W_DEF,
    parameter int C1    = C1_DEF,
    parameter int C2    = C2_DEF,
    parameter int C3    = C3_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_1,
    input  logic signed [IN_W-1:0]  in_2,
    input  logic signed [IN_W-1:0]  in_3,
    input  logic signed [IN_W-1:0]  in_4,
    input  logic signed [IN_W-1:0]  in_5,
    input  logic signed [IN_W-1:0]  in_6,
    input  logic signed [B_W-1:0]   b,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag
);

    localparam int ACC_W = IN_W + 6;
    localparam int S1_W  = 3 * ACC_W + B_W + TAG_W;

    // Constant coefficient multiply as a shift-add over the 4-bit magnitude.
    function automatic logic signed [ACC_W-1:0] cmul(input logic signed [IN_W:0] x, input int c);
        logic signed [ACC_W-1:0] xe;
        logic signed [ACC_W-1:0] sum;
        int unsigned mag;
        xe  = ACC_W'(x);
        sum = '0;
        mag = (c < 0) ? -c : c;
        for (int unsigned k = 0; k < 4; k++) begin
            if (mag[k]) begin
                sum = sum + (xe <<< k);
            end
        end
        return (c < 0) ? -sum : sum;
    endfunction

    // Stage 1: pair sums and coefficient products
    logic signed [IN_W:0]    sum12, sum34, sum56;
    logic signed [ACC_W-1:0] p1, p2, p3;

    assign sum12 = (IN_W+1)'(in_1) + (IN_W+1)'(in_2);
    assign sum34 = (IN_W+1)'(in_3) + (IN_W+1)'(in_4);
    assign sum56 = (IN_W+1)'(in_5) + (IN_W+1)'(in_6);
    assign p1 = cmul(sum12, C1);
    assign p2 = cmul(sum34, C2);
    assign p3 = cmul(sum56, C3);

    logic              s1_in_ready;
    logic              s1_valid;
    logic              s2_in_ready;
    logic [S1_W-1:0]   s1_data;

    assign in_ready = s1_in_ready && !reset;

    gsim_pe_slot #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (s1_in_ready),
        .in_data   ({p1, p2, p3, b, in_tag}),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_data)
    );

    // Stage 2: accumulate
    logic signed [ACC_W-1:0] s1_p1, s1_p2, s1_p3;
    logic signed [B_W-1:0]   s1_b;
    logic [TAG_W-1:0]        s1_tag;
    logic signed [ACC_W-1:0] acc;

    assign {s1_p1, s1_p2, s1_p3, s1_b, s1_tag} = s1_data;
    assign acc = ACC_W'(s1_b) + s1_p1 + s1_p2 + s1_p3;

`ifdef GSIM_PE_DIV_EN
    localparam int PW   = ACC_W + 13;
    localparam int S2_W = ACC_W + TAG_W;
    localparam int S3_W = OUT_W + TAG_W;

    logic             s2_valid;
    logic             s3_in_ready;
    logic [S2_W-1:0]  s2_data;
    logic [S3_W-1:0]  s3_data;

    gsim_pe_slot #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   ({acc, s1_tag}),
        .out_valid (s2_valid),
        .out_ready (s3_in_ready),
        .out_data  (s2_data)
    );

    // Stage 3: floor scaling by 3277/65536
    logic signed [ACC_W-1:0] s2_acc;
    logic [TAG_W-1:0]        s2_tag;
    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    scaled;

    assign {s2_acc, s2_tag} = s2_data;
    assign prod   = PW'(s2_acc) * PW'(DIV_MUL);
    assign scaled = prod >>> DIV_SHIFT;

    gsim_pe_slot #(.W(S3_W)) u_s3 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s2_valid),
        .in_ready  (s3_in_ready),
        .in_data   ({OUT_W'(scaled), s2_tag}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s3_data)
    );

    assign {out_data, out_tag} = s3_data;
`else
    localparam int S2_W = OUT_W + TAG_W;

    logic [S2_W-1:0] s2_data;

    // Wrap to OUT_W before registering; the truncation is identical either side of the slot.
    gsim_pe_slot #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   ({OUT_W'(acc), s1_tag}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_data)
    );

    assign {out_data, out_tag} = s2_data;
`endif

endmodule

// File: tb/tb_gsim_pe_pipe.sv
// Directed and streamed checks of gsim_pe_pipe; follows GSIM_PE_DIV_EN for expected values and latency.
module tb_gsim_pe_pipe;
    import gsim_pkg::*;

`ifdef GSIM_PE_DIV_EN
    localparam bit DIV = 1'b1;
`else
    localparam bit DIV = 1'b0;
`endif
    localparam int LAT = gsim_lat(DIV);
    localparam int IW  = 34;
    localparam int BW  = 16;
    localparam int OW  = 38;
    localparam int TW  = 10;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [IW-1:0] in_1 = '0, in_2 = '0, in_3 = '0, in_4 = '0, in_5 = '0, in_6 = '0;
    logic signed [BW-1:0] b = '0;
    logic [TW-1:0]        in_tag = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out_data;
    logic [TW-1:0]        out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gsim_pe_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_1      (in_1),
        .in_2      (in_2),
        .in_3      (in_3),
        .in_4      (in_4),
        .in_5      (in_5),
        .in_6      (in_6),
        .b         (b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    function automatic logic [OW-1:0] model(input logic signed [IW-1:0] x1, x2, x3, x4, x5, x6,
                                            input logic signed [BW-1:0] bb);
        longint acc;
        acc = longint'(bb) + (longint'(x1) + longint'(x2))
            - 6 * (longint'(x3) + longint'(x4))
            + 13 * (longint'(x5) + longint'(x6));
        if (DIV) acc = (acc * 3277) >>> 16;
        return acc[OW-1:0];
    endfunction

    task automatic set_ops(input logic signed [IW-1:0] x1, x2, x3, x4, x5, x6,
                           input logic signed [BW-1:0] bb, input logic [TW-1:0] tg);
        in_1 = x1; in_2 = x2; in_3 = x3; in_4 = x4; in_5 = x5; in_6 = x6;
        b = bb; in_tag = tg;
    endtask

    // Present one set at posedge+1, expect it at exactly LAT cycles, then an empty pipe.
    task automatic send_one(input string name, input logic signed [IW-1:0] x1, x2, x3, x4, x5, x6,
                            input logic signed [BW-1:0] bb, input logic [TW-1:0] tg,
                            input logic signed [OW-1:0] exp_d);
        set_ops(x1, x2, x3, x4, x5, x6, bb, tg);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL %s_accept in_ready=%b want 1", name, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= LAT; i++) begin
            @(negedge clk);
            total++;
            if (i < LAT) begin
                if (out_valid !== 1'b0) begin
                    bad++; $display("FAIL %s_early cycle=%0d out_valid=%b want 0", name, i, out_valid);
                end
            end else if (out_valid !== 1'b1 || out_data !== exp_d || out_tag !== tg) begin
                bad++;
                $display("FAIL %s_result valid=%b data=%0d tag=%0d want valid=1 data=%0d tag=%0d",
                         name, out_valid, out_data, out_tag, exp_d, tg);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL %s_residue out_valid=%b want 0", name, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_valid = 1'b1;
        set_ops(0, 0, 0, 0, 100, 100, 0, 7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want 0", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want 0", out_valid); end
        total++;
        if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%0d want 0", out_data); end
        total++;
        if (out_tag !== '0) begin bad++; $display("FAIL reset_out_tag got=%0d want 0", out_tag); end
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want 1", in_ready); end
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL reset_ignored cycle=%0d out_valid=%b want 0", i, out_valid);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        send_one("c3_pair", 0, 0, 0, 0, 100, 100, 0, 5, DIV ? 38'sd130 : 38'sd2600);
        send_one("c2_floor", 0, 0, 10, 10, 0, 0, 0, 6, DIV ? -38'sd7 : -38'sd120);
        send_one("ones_bneg", 1, 1, 1, 1, 1, 1, -16, 7, 38'sd0);
        send_one("ones_bpos", 1, 1, 1, 1, 1, 1, 4, 8, DIV ? 38'sd1 : 38'sd20);
    endtask

    // Continuous in_valid; scoreboard checks order, values, tags, stall stability and in_ready.
    task automatic test_stream(input string name, input int n, input bit rand_ready);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int occ;
        bit need_new = 1'b1;
        bit stalled  = 1'b0;
        logic [OW-1:0] held_d = '0;
        logic [TW-1:0] held_t = '0;
        logic [OW-1:0] ed;
        logic [TW-1:0] et;
        logic          exp_rdy;
        logic [OW-1:0] qd[$];
        logic [TW-1:0] qt[$];
        while (got < n && cyc < 20 * n + 100) begin
            if (sent < n) begin
                if (need_new) begin
                    set_ops(IW'({$urandom(), $urandom()}), IW'({$urandom(), $urandom()}),
                            IW'({$urandom(), $urandom()}), IW'({$urandom(), $urandom()}),
                            IW'({$urandom(), $urandom()}), IW'({$urandom(), $urandom()}),
                            BW'($urandom()), TW'(sent));
                    need_new = 1'b0;
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            @(negedge clk);
            occ = sent - got;
            exp_rdy = (occ == LAT && !out_ready) ? 1'b0 : 1'b1;
            total++;
            if (in_ready !== exp_rdy) begin
                bad++; $display("FAIL %s_in_ready cyc=%0d got=%b want %b", name, cyc, in_ready, exp_rdy);
            end
            if (stalled) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== held_d || out_tag !== held_t) begin
                    bad++;
                    $display("FAIL %s_stall_hold cyc=%0d valid=%b data=%0d tag=%0d want valid=1 data=%0d tag=%0d",
                             name, cyc, out_valid, out_data, out_tag, held_d, held_t);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (qd.size() == 0) begin
                    bad++; $display("FAIL %s_extra cyc=%0d data=%0d tag=%0d want none", name, cyc, out_data, out_tag);
                end else begin
                    ed = qd.pop_front();
                    et = qt.pop_front();
                    if (out_data !== ed || out_tag !== et) begin
                        bad++;
                        $display("FAIL %s_result cyc=%0d data=%0d tag=%0d want data=%0d tag=%0d",
                                 name, cyc, out_data, out_tag, ed, et);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                qd.push_back(model(in_1, in_2, in_3, in_4, in_5, in_6, b));
                qt.push_back(in_tag);
                sent++;
                need_new = 1'b1;
            end
            stalled = out_valid && !out_ready;
            held_d  = out_data;
            held_t  = out_tag;
            cyc++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (got != n) begin bad++; $display("FAIL %s_count got=%0d want %0d", name, got, n); end
        if (!rand_ready) begin
            total++;
            if (cyc != n + LAT) begin bad++; $display("FAIL %s_throughput cycles=%0d want %0d", name, cyc, n + LAT); end
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain out_valid=%b want 0", name, out_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset();
        int accepted = 0;
        bit rdy;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            set_ops(IW'(k + 1), 0, 0, 0, 0, 0, 0, TW'(200 + k));
            in_valid = 1'b1;
            @(negedge clk);
            rdy = in_ready;
            if (rdy) accepted++;
            @(posedge clk); #1;
            if (!rdy) break;
        end
        in_valid = 1'b0;
        total++;
        if (accepted != LAT) begin bad++; $display("FAIL full_depth stored=%0d want %0d", accepted, LAT); end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_tag !== TW'(200)) begin
            bad++; $display("FAIL full_head valid=%b tag=%0d want valid=1 tag=200", out_valid, out_tag);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_clear valid=%b data=%0d tag=%0d in_ready=%b want 0 0 0 1",
                     out_valid, out_data, out_tag, in_ready);
        end
        @(posedge clk); #1;
        send_one("after_reset", 5, 5, -3, -3, 2, 2, 7, 9, DIV ? 38'sd5 : 38'sd105);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream("b2b", 100, 1'b0);
        test_stream("rand", 200, 1'b1);
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
